uart_reg_bank: RTL and testbench
================================

// Module: uart_reg_bank
// PURPOSE
//  Command-execution stage directly downstream of the UART command controller.
//  Services its single-byte read/write requests (addr/data_com/rreq/wreq) against an 8-bit register map:
//  - game configuration registers
//  - read-only status bytes
//  - ID and error-counter registers
//  Returns read data on data_out and closes every access with a one-cycle com_done pulse.
// PARAMETERS
//  NUM_CFG    16     number of R/W config registers at 0x00..NUM_CFG-1 (1..16)
//  CFG_RESET  8'h00  reset value of every config register
//  ID_VALUE   8'h5A  constant returned at address 0x20
// PORTS
//  clk        in   1          system clock
//  reset      in   1          asynchronous, active-high reset
//  addr       in   8          register address from controller
//  data_com   in   8          write data from controller
//  rreq       in   1          read request (level, held until com_done seen)
//  wreq       in   1          write request (level, held until com_done seen)
//  com_done   out  1          one-cycle access-complete pulse
//  data_out   out  8          read data, valid with com_done, held until next read
//  status_in  in   32         live game status, bytes at 0x10(LSB)..0x13(MSB)
//  cfg_regs   out  8*NUM_CFG  flat config bus, reg n at [8n+7:8n]
//  wr_strobe  out  1          one-cycle pulse when a config register is written
//  wr_addr    out  8          address of last config write, valid with wr_strobe
// BEHAVIOUR
//  Reset (async, active-high):
//  - state=IDLE; com_done=0, data_out=0, wr_strobe=0, wr_addr=0
//  - cfg_regs=all CFG_RESET; err_cnt=0
//  FSM: IDLE -> EXEC -> DONE -> RELEASE -> IDLE
//  - IDLE: (rreq|wreq) sampled high in cycle N -> latch addr, data_com, and request type; go to EXEC.
//  - EXEC (N+1):
//    - Read: data_out <= mux(addr); status bytes are sampled in this cycle.
//    - Write: target register updated; wr_strobe/wr_addr pulse if target is a config register.
//  - DONE (N+2): com_done=1 for exactly one cycle.
//  - RELEASE: wait until rreq==0 && wreq==0, then IDLE.
//    Guarantees exactly one execution per request regardless of how long the controller holds the request.
//  Address map:
//  - 0x00..NUM_CFG-1: config registers, R/W
//  - 0x10..0x13: status_in bytes, RO; writes are ignored and do not count as errors
//  - 0x20: ID_VALUE, RO
//  - 0x21: err_cnt. Read returns count. Any write clears it to 0.
//  - All other addresses: read returns 8'h00, write ignored; err_cnt++.
//  err_cnt is 8-bit and saturates at 8'hFF (no wrap).
//  Simultaneous rreq & wreq in IDLE is a protocol error:
//  - no register is modified
//  - data_out <= 8'hEE; err_cnt++ (saturating)
//  - com_done still pulses at N+2
//  Request dropped before DONE: the access completes anyway; com_done still pulses.
//  Reset mid-access: aborts immediately; no com_done; register contents return to reset values.
//  data_out changes only in EXEC of a read (or of the protocol-error case).
// CONFIGURATION
//  UART_REG_LOCK_EN:
//  - Defined:
//    - Address 0x22 is a lock register; reset state is locked. Writing 8'hA5 unlocks, any other value locks.
//    - Reading 0x22 returns {7'b0, unlocked}.
//    - Config writes while locked: register unchanged, no wr_strobe, err_cnt++, com_done still pulses.
//  - Undefined: 0x22 is unmapped (normal unmapped rules); config registers are always writable.
// TESTING
//  - wreq, addr=0x03, data_com=0x7C, held 6 cycles
//    -> cfg reg 3 =0x7C; exactly one wr_strobe (wr_addr=0x03); one com_done 2 cycles after request.
//  - status_in=32'hDEADBEEF; read 0x12 -> data_out=0xAD with com_done; read 0x20 -> 0x5A.
//  - 300 reads of unmapped 0x40, then read 0x21 -> 0xFF; write 0x21 any value, read 0x21 -> 0x00.
//  - rreq=wreq=1, addr=0x01 -> data_out=0xEE, cfg reg 1 unchanged, err_cnt=1, com_done once.
//  - Assert reset during EXEC of a write to 0x05 -> no com_done; cfg reg 5=CFG_RESET; next access works normally.
//  - UART_REG_LOCK_EN defined:
//    - write 0x00=0x11 while locked -> unchanged, err_cnt=1
//    - write 0x22=0xA5, then write 0x00=0x11 -> reg 0=0x11

Source files
------------

// File: rtl/uart_reg_bank.sv
// Register bank that executes single-byte read/write commands from the UART command controller.
// Optional macro UART_REG_LOCK_EN adds a write-lock register at 0x22 guarding the config registers.
module uart_reg_bank #(
  parameter int         NUM_CFG   = 16,
  parameter logic [7:0] CFG_RESET = 8'h00,
  parameter logic [7:0] ID_VALUE  = 8'h5A
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             addr,
  input  logic [7:0]             data_com,
  input  logic                   rreq,
  input  logic                   wreq,
  output logic                   com_done,
  output logic [7:0]             data_out,
  input  logic [31:0]            status_in,
  output logic [8*NUM_CFG-1:0]   cfg_regs,
  output logic                   wr_strobe,
  output logic [7:0]             wr_addr
);

  localparam logic [7:0] CFG_LIMIT = 8'(NUM_CFG);

  typedef enum logic [1:0] {IDLE, EXEC, DONE, RELEASE} state_t;
  typedef enum logic [1:0] {REQ_READ, REQ_WRITE, REQ_BAD} req_t;

  state_t     state, state_next;
  req_t       req_type;
  logic [7:0] lat_addr;
  logic [7:0] lat_data;
  logic [7:0] err_cnt;
  logic [7:0] rd_mux;
  logic       addr_cfg, addr_status, addr_id, addr_err, addr_lock, addr_unmapped;
  logic       cfg_wr_ok, exec_write, err_bump, err_clear;

`ifdef UART_REG_LOCK_EN
  logic       unlocked;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    com_done   = 1'b0;
    case (state)
      IDLE:    if (rreq || wreq) state_next = EXEC;
      EXEC:    state_next = DONE;
      DONE: begin
        com_done   = 1'b1;
        state_next = RELEASE;
      end
      RELEASE: if (!rreq && !wreq) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the request once; the controller may hold or drop its lines afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_addr <= 8'h00;
      lat_data <= 8'h00;
      req_type <= REQ_READ;
    end else if (state == IDLE && (rreq || wreq)) begin
      lat_addr <= addr;
      lat_data <= data_com;
      if (rreq && wreq)  req_type <= REQ_BAD;
      else if (rreq)     req_type <= REQ_READ;
      else               req_type <= REQ_WRITE;
    end
  end

  always_comb begin
    addr_cfg    = (lat_addr < CFG_LIMIT);
    addr_status = (lat_addr[7:2] == 6'h04);
    addr_id     = (lat_addr == 8'h20);
    addr_err    = (lat_addr == 8'h21);
`ifdef UART_REG_LOCK_EN
    addr_lock   = (lat_addr == 8'h22);
    cfg_wr_ok   = addr_cfg && unlocked;
`else
    addr_lock   = 1'b0;
    cfg_wr_ok   = addr_cfg;
`endif
    addr_unmapped = !(addr_cfg || addr_status || addr_id || addr_err || addr_lock);
  end

  always_comb begin
    rd_mux = 8'h00;
    if (addr_cfg) begin
      for (int i = 0; i < NUM_CFG; i++)
        if (lat_addr == 8'(i)) rd_mux = cfg_regs[8*i +: 8];
    end else if (addr_status) begin
      case (lat_addr[1:0])
        2'd0:    rd_mux = status_in[7:0];
        2'd1:    rd_mux = status_in[15:8];
        2'd2:    rd_mux = status_in[23:16];
        default: rd_mux = status_in[31:24];
      endcase
    end else if (addr_id) begin
      rd_mux = ID_VALUE;
    end else if (addr_err) begin
      rd_mux = err_cnt;
`ifdef UART_REG_LOCK_EN
    end else if (addr_lock) begin
      rd_mux = {7'b0, unlocked};
`endif
    end
  end

  // A blocked config write (lock engaged) counts as an error like an unmapped access.
  always_comb begin
    exec_write = (state == EXEC) && (req_type == REQ_WRITE);
    err_clear  = exec_write && addr_err;
    err_bump   = (state == EXEC) &&
                 ((req_type == REQ_BAD) ||
                  ((req_type != REQ_BAD) && addr_unmapped) ||
                  (exec_write && addr_cfg && !cfg_wr_ok));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          err_cnt <= 8'h00;
    else if (err_clear)                 err_cnt <= 8'h00;
    else if (err_bump && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= 8'h00;
    end else if (state == EXEC) begin
      if (req_type == REQ_BAD)       data_out <= 8'hEE;
      else if (req_type == REQ_READ) data_out <= rd_mux;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_regs  <= {NUM_CFG{CFG_RESET}};
      wr_strobe <= 1'b0;
      wr_addr   <= 8'h00;
    end else begin
      wr_strobe <= exec_write && cfg_wr_ok;
      if (exec_write && cfg_wr_ok) begin
        wr_addr <= lat_addr;
        for (int i = 0; i < NUM_CFG; i++)
          if (lat_addr == 8'(i)) cfg_regs[8*i +: 8] <= lat_data;
      end
    end
  end

`ifdef UART_REG_LOCK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       unlocked <= 1'b0;
    else if (exec_write && addr_lock) unlocked <= (lat_data == 8'hA5);
  end
`endif

endmodule

// File: tb/tb_uart_reg_bank.sv
// Directed self-checking bench for uart_reg_bank; define UART_REG_LOCK_EN to also cover the lock register.
module tb_uart_reg_bank;

  logic         clk;
  logic         reset;
  logic [7:0]   addr;
  logic [7:0]   data_com;
  logic         rreq;
  logic         wreq;
  logic         com_done;
  logic [7:0]   data_out;
  logic [31:0]  status_in;
  logic [127:0] cfg_regs;
  logic         wr_strobe;
  logic [7:0]   wr_addr;

  int checks = 0;
  int errors = 0;

  uart_reg_bank #(.NUM_CFG(16), .CFG_RESET(8'h00), .ID_VALUE(8'h5A)) dut (
    .clk(clk), .reset(reset), .addr(addr), .data_com(data_com),
    .rreq(rreq), .wreq(wreq), .com_done(com_done), .data_out(data_out),
    .status_in(status_in), .cfg_regs(cfg_regs), .wr_strobe(wr_strobe), .wr_addr(wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] cfgReg(input int n);
    return cfg_regs[8*n +: 8];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    rreq     = rd;
    wreq     = wr;
    addr     = a;
    data_com = d;
  endtask

  // Drives one request (from just after a falling edge), holds it 'hold' cycles,
  // and records com_done / wr_strobe activity seen on each following falling edge.
  task automatic runAccess(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                           input int hold, output int done_cnt, output int done_cycle,
                           output logic [7:0] done_data, output int strobe_cnt,
                           output logic [7:0] strobe_addr);
    done_cnt    = 0;
    done_cycle  = 0;
    done_data   = 8'h00;
    strobe_cnt  = 0;
    strobe_addr = 8'h00;
    applyStimulus(rd, wr, a, d);
    for (int c = 1; c <= hold + 4; c++) begin
      @(negedge clk);
      if (c == hold) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
      if (com_done) begin
        done_cnt++;
        done_cycle = c;
        done_data  = data_out;
      end
      if (wr_strobe) begin
        strobe_cnt++;
        strobe_addr = wr_addr;
      end
    end
  endtask

  int         dc, dcy, sc, cnt;
  logic [7:0] dd, sa;

  initial begin
    reset     = 1'b1;
    status_in = 32'hDEADBEEF;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    checkOutput("rst_com_done", com_done, 0);
    checkOutput("rst_data_out", data_out, 8'h00);
    checkOutput("rst_wr_strobe", wr_strobe, 0);
    checkOutput("rst_wr_addr", wr_addr, 8'h00);
    for (int i = 0; i < 16; i++) checkOutput("rst_cfg", cfgReg(i), 8'h00);
    reset = 1'b0;
    @(negedge clk);

`ifdef UART_REG_LOCK_EN
    $display("[TB] lock register checks");
    runAccess(1'b0, 1'b1, 8'h00, 8'h11, 2, dc, dcy, dd, sc, sa);
    checkOutput("lock_blocked_reg0", cfgReg(0), 8'h00);
    checkOutput("lock_blocked_strobe", sc, 0);
    checkOutput("lock_blocked_done", dc, 1);
    runAccess(1'b1, 1'b0, 8'h21, 8'h00, 2, dc, dcy, dd, sc, sa);
    checkOutput("lock_blocked_err", dd, 8'h01);
    runAccess(1'b1, 1'b0, 8'h22, 8'h00, 2, dc, dcy, dd, sc, sa);
    checkOutput("lock_read_locked", dd, 8'h00);
    runAccess(1'b0, 1'b1, 8'h22, 8'hA5, 2, dc, dcy, dd, sc, sa);
    runAccess(1'b1, 1'b0, 8'h22, 8'h00, 2, dc, dcy, dd, sc, sa);
    checkOutput("lock_read_unlocked", dd, 8'h01);
    runAccess(1'b0, 1'b1, 8'h00, 8'h11, 2, dc, dcy, dd, sc, sa);
    checkOutput("lock_open_reg0", cfgReg(0), 8'h11);
    runAccess(1'b0, 1'b1, 8'h21, 8'h00, 2, dc, dcy, dd, sc, sa);
`endif

    // Long-held write: exactly one execution.
    runAccess(1'b0, 1'b1, 8'h03, 8'h7C, 6, dc, dcy, dd, sc, sa);
    checkOutput("wr3_reg", cfgReg(3), 8'h7C);
    checkOutput("wr3_strobe_cnt", sc, 1);
    checkOutput("wr3_strobe_addr", sa, 8'h03);
    checkOutput("wr3_done_cnt", dc, 1);
    checkOutput("wr3_done_cycle", dcy, 2);

    runAccess(1'b1, 1'b0, 8'h12, 8'h00, 2, dc, dcy, dd, sc, sa);
    checkOutput("rd_status2", dd, 8'hAD);
    checkOutput("rd_status2_done", dc, 1);
    runAccess(1'b1, 1'b0, 8'h10, 8'h00, 2, dc, dcy, dd, sc, sa);
    checkOutput("rd_status0", dd, 8'hEF);
    runAccess(1'b1, 1'b0, 8'h13, 8'h00, 1, dc, dcy, dd, sc, sa);
    checkOutput("rd_status3_early_drop", dd, 8'hDE);
    checkOutput("rd_status3_done", dc, 1);
    runAccess(1'b1, 1'b0, 8'h20, 8'h00, 2, dc, dcy, dd, sc, sa);
    checkOutput("rd_id", dd, 8'h5A);
    runAccess(1'b1, 1'b0, 8'h03, 8'h00, 2, dc, dcy, dd, sc, sa);
    checkOutput("rd_cfg3", dd, 8'h7C);

    // Status writes are silently ignored.
    runAccess(1'b0, 1'b1, 8'h11, 8'h55, 2, dc, dcy, dd, sc, sa);
    checkOutput("wr_status_strobe", sc, 0);
    checkOutput("wr_status_data_held", data_out, 8'h7C);
    runAccess(1'b1, 1'b0, 8'h21, 8'h00, 2, dc, dcy, dd, sc, sa);
    checkOutput("err_after_status_wr", dd, 8'h00);

`ifndef UART_REG_LOCK_EN
    runAccess(1'b1, 1'b0, 8'h22, 8'h00, 2, dc, dcy, dd, sc, sa);
    checkOutput("rd_unmapped_22", dd, 8'h00);
    runAccess(1'b1, 1'b0, 8'h21, 8'h00, 2, dc, dcy, dd, sc, sa);
    checkOutput("err_after_22", dd, 8'h01);
`endif

    runAccess(1'b0, 1'b1, 8'h30, 8'h12, 2, dc, dcy, dd, sc, sa);
    checkOutput("wr_unmapped_strobe", sc, 0);
    checkOutput("wr_unmapped_done", dc, 1);

    $display("[TB] 300 unmapped reads");
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      runAccess(1'b1, 1'b0, 8'h40, 8'h00, 1, dc, dcy, dd, sc, sa);
      if (dc == 1 && dd == 8'h00) cnt++;
    end
    checkOutput("unmapped_reads_ok", cnt, 300);
    runAccess(1'b1, 1'b0, 8'h21, 8'h00, 2, dc, dcy, dd, sc, sa);
    checkOutput("err_saturated", dd, 8'hFF);
    runAccess(1'b0, 1'b1, 8'h21, 8'h3C, 2, dc, dcy, dd, sc, sa);
    runAccess(1'b1, 1'b0, 8'h21, 8'h00, 2, dc, dcy, dd, sc, sa);
    checkOutput("err_cleared", dd, 8'h00);

    // Simultaneous read and write requests.
    runAccess(1'b1, 1'b1, 8'h01, 8'h99, 3, dc, dcy, dd, sc, sa);
    checkOutput("proto_data", dd, 8'hEE);
    checkOutput("proto_done_cnt", dc, 1);
    checkOutput("proto_done_cycle", dcy, 2);
    checkOutput("proto_reg1", cfgReg(1), 8'h00);
    checkOutput("proto_strobe", sc, 0);
    runAccess(1'b1, 1'b0, 8'h21, 8'h00, 2, dc, dcy, dd, sc, sa);
    checkOutput("proto_err_cnt", dd, 8'h01);

    // Reset lands while the write to 0x05 is in EXEC.
    applyStimulus(1'b0, 1'b1, 8'h05, 8'h33);
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (com_done) cnt++;
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (com_done) cnt++;
    end
    checkOutput("midrst_no_done", cnt, 0);
    checkOutput("midrst_reg5", cfgReg(5), 8'h00);
    checkOutput("midrst_reg3", cfgReg(3), 8'h00);
    checkOutput("midrst_data_out", data_out, 8'h00);

`ifdef UART_REG_LOCK_EN
    runAccess(1'b0, 1'b1, 8'h22, 8'hA5, 2, dc, dcy, dd, sc, sa);
`endif
    runAccess(1'b1, 1'b0, 8'h21, 8'h00, 2, dc, dcy, dd, sc, sa);
    checkOutput("midrst_err_cnt", dd, 8'h00);
    runAccess(1'b0, 1'b1, 8'h05, 8'h44, 2, dc, dcy, dd, sc, sa);
    checkOutput("post_rst_reg5", cfgReg(5), 8'h44);
    checkOutput("post_rst_done", dc, 1);
    checkOutput("post_rst_strobe_addr", sa, 8'h05);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
